// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Decode / operand-fetch stage in front of a 16x16 register
//               file. Splits the instruction into register indices, forwards
//               same-cycle writeback data into the captured operands, stalls
//               RAW/WAW hazards with a per-register busy scoreboard and hands
//               registered operands to execute over valid/ready.
//               Optional feature: define OFS_STALL_CNT_EN to add the
//               saturating hazard-stall counter output stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
    parameter int          DW      = 16,
    parameter int          AW      = 4,
    parameter logic [15:0] WR_MASK = 16'h00FF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic [AW-1:0] rf_rw,
    output logic [AW-1:0] rf_rs1,
    output logic [AW-1:0] rf_rs2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    input  logic [DW-1:0] rf_rd3,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [AW-1:0] out_rw,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_c
`ifdef OFS_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int NREG = 1 << AW;

    logic [3:0]      w_op;
    logic            w_clr_rs1;
    logic            w_clr_rs2;
    logic            w_clr_rw;
    logic            w_hazard;
    logic            w_fire;
    logic [NREG-1:0] w_busy_nxt;

    logic [NREG-1:0] r_busy;
    logic            r_out_valid;
    logic [3:0]      r_out_op;
    logic [AW-1:0]   r_out_rw;
    logic [DW-1:0]   r_out_a;
    logic [DW-1:0]   r_out_b;
    logic [DW-1:0]   r_out_c;

    // Field split drives the register file read ports directly.
    assign w_op   = in_instr[15:12];
    assign rf_rw  = in_instr[8 +: AW];
    assign rf_rs1 = in_instr[4 +: AW];
    assign rf_rs2 = in_instr[0 +: AW];

    // A writeback to an index this cycle both clears its busy bit and
    // supplies its value, so it never counts as a hazard.
    assign w_clr_rs1 = wb_en && (wb_addr == rf_rs1);
    assign w_clr_rs2 = wb_en && (wb_addr == rf_rs2);
    assign w_clr_rw  = wb_en && (wb_addr == rf_rw);

    // rw is always checked: WAW for writers, RAW for the store-data read.
    assign w_hazard = (r_busy[rf_rs1] && !w_clr_rs1)
                    | (r_busy[rf_rs2] && !w_clr_rs2)
                    | (r_busy[rf_rw]  && !w_clr_rw);

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_fire   = in_valid && in_ready;

    // Scoreboard next state: clear on writeback first so a same-index set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_fire && WR_MASK[w_op]) begin
            w_busy_nxt[rf_rw] = 1'b1;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Output operand register: capture with forwarding on fire, drain when
    // consumed, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_rw    <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_c     <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_op    <= w_op;
            r_out_rw    <= rf_rw;
            r_out_a     <= w_clr_rs1 ? wb_data : rf_rd1;
            r_out_b     <= w_clr_rs2 ? wb_data : rf_rd2;
            r_out_c     <= w_clr_rw  ? wb_data : rf_rd3;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_rw    = r_out_rw;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_c     = r_out_c;

`ifdef OFS_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where an offered instruction is stalled by a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Self-checking bench for operand_fetch_stage: directed
//               vectors with literal expectations plus a per-cycle
//               comparison against a behavioural scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

    localparam logic [15:0] WR_MASK = 16'h00FF;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [3:0]  rf_rw;
    logic [3:0]  rf_rs1;
    logic [3:0]  rf_rs2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic [15:0] rf_rd3;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [3:0]  out_rw;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_c;
`ifdef OFS_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch_stage #(
        .DW      (16),
        .AW      (4),
        .WR_MASK (WR_MASK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .rf_rw     (rf_rw),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .rf_rd3    (rf_rd3),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rw    (out_rw),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c)
`ifdef OFS_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [3:0]  m_op;
    logic [3:0]  m_rw;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_c;
    logic        m_busy [16];
    int          m_stall;

    // Inputs change just after posedge; on negedge they are the ones the next
    // posedge will sample, so compare first, then advance the model.
    always @(negedge clk) begin : model
        logic [3:0] op, rw, rs1, rs2;
        logic       hz, rdy, fire;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_op = '0; m_rw = '0; m_a = '0; m_b = '0; m_c = '0;
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            m_stall = 0;
        end
        op  = in_instr[15:12];
        rw  = in_instr[11:8];
        rs1 = in_instr[7:4];
        rs2 = in_instr[3:0];
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_op", {28'd0, out_op}, {28'd0, m_op});
        chk("out_rw", {28'd0, out_rw}, {28'd0, m_rw});
        chk("out_a", {16'd0, out_a}, {16'd0, m_a});
        chk("out_b", {16'd0, out_b}, {16'd0, m_b});
        chk("out_c", {16'd0, out_c}, {16'd0, m_c});
        chk("rf_idx", {20'd0, rf_rw, rf_rs1, rf_rs2}, {20'd0, rw, rs1, rs2});
`ifdef OFS_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
        hz = (m_busy[rs1] && !(wb_en && wb_addr == rs1))
          || (m_busy[rs2] && !(wb_en && wb_addr == rs2))
          || (m_busy[rw]  && !(wb_en && wb_addr == rw));
        rdy = (!m_valid || out_ready) && !hz;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        if (rst_n) begin
            if (in_valid && hz && m_stall < 65535) m_stall++;
            fire = in_valid && rdy;
            if (fire) begin
                m_valid = 1'b1;
                m_op = op;
                m_rw = rw;
                m_a = (wb_en && wb_addr == rs1) ? wb_data : rf_rd1;
                m_b = (wb_en && wb_addr == rs2) ? wb_data : rf_rd2;
                m_c = (wb_en && wb_addr == rw)  ? wb_data : rf_rd3;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (fire && WR_MASK[op]) m_busy[rw] = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3, input logic we,
                         input logic [3:0] wa, input logic [15:0] wd, input logic ordy);
        in_valid = v; in_instr = ins;
        rf_rd1 = d1; rf_rd2 = d2; rf_rd3 = d3;
        wb_en = we; wb_addr = wa; wb_data = wd;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 16'h0000, 16'hDADA, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        step(); step();
        #1;
        chk("t1_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_rst_a", {16'd0, out_a}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t1_ready", {31'd0, in_ready}, 32'd1);

        // Writer op1 to F
        drive(1, 16'h1F21, 16'h0002, 16'h0001, 16'h0033, 0, 4'h0, 16'h0000, 1);
        step();
        drive(1, 16'h23F0, 16'h1111, 16'h2222, 16'h3333, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_a", {16'd0, out_a}, 32'h0002);
        chk("t2_b", {16'd0, out_b}, 32'h0001);
        chk("t2_rw", {28'd0, out_rw}, 32'hF);
        chk("t3_raw_stall", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        chk("t3_still_stalled", {31'd0, in_ready}, 32'd0);
        chk("t3_drained", {31'd0, out_valid}, 32'd0);
        drive(1, 16'h23F0, 16'h1111, 16'h2222, 16'h3333, 1, 4'hF, 16'hDADA, 1);
        #1;
        chk("t3_fwd_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Back-pressure
        drive(1, 16'h4500, 16'h0A0A, 16'h0B0B, 16'h0C0C, 0, 4'h0, 16'h0000, 0);
        #1;
        chk("t3_fwd_a", {16'd0, out_a}, 32'hDADA);
        chk("t3_op", {28'd0, out_op}, 32'h2);
        chk("t3_c", {16'd0, out_c}, 32'h3333);
        chk("t4_bp_ready", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_hold_op", {28'd0, out_op}, 32'h2);
        chk("t4_hold_a", {16'd0, out_a}, 32'hDADA);
        drive(1, 16'h4500, 16'h0A0A, 16'h0B0B, 16'h0C0C, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t4_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        drive(1, 16'h6700, 16'h0606, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t4_op4", {28'd0, out_op}, 32'h4);
        chk("t4_a4", {16'd0, out_a}, 32'h0A0A);
        chk("t4_b2b_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Non-writer opcode 8 on rw=3 (forwarded clear of busy[3])
        drive(1, 16'h8300, 16'h0000, 16'h0000, 16'h0C0C, 1, 4'h3, 16'h5555, 1);
        #1;
        chk("t4_b2b_op6", {28'd0, out_op}, 32'h6);
        chk("t4_b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        step();
        drive(1, 16'hA031, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t5_fwd_c", {16'd0, out_c}, 32'h5555);
        chk("t5_nonwriter_ready", {31'd0, in_ready}, 32'd1);
        step();
        drive(1, 16'h1300, 16'h0000, 16'h0000, 16'h0000, 1, 4'h3, 16'h7777, 1);
        #1;
        chk("t5_setclr_ready", {31'd0, in_ready}, 32'd1);
        step();
        drive(1, 16'hA030, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t5_set_wins", {31'd0, in_ready}, 32'd0);
        step();

        // Clear 3,5,7 then build busy = 16'h8004
        drive(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 4'h3, 16'h0000, 1); step();
        drive(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 4'h5, 16'h0000, 1); step();
        drive(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 4'h7, 16'h0000, 1); step();
        drive(1, 16'h1F00, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1); step();
        drive(1, 16'h1200, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1); step();
        drive(0, 16'h0F2F, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 0);
        #1;
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_async_op", {28'd0, out_op}, 32'h0);
        step();
        rst_n = 1'b1;
        drive(1, 16'h0F2F, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t6_busy_cleared", {31'd0, in_ready}, 32'd1);
        step();
`ifdef OFS_STALL_CNT_EN
        drive(1, 16'h1500, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        step();
        drive(1, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        step(); step(); step();
        drive(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        #1;
        chk("t6_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif
        drive(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 1);
        step(); step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
